// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder
// Receives PS/2 Set-2 scan-code frames and drives held-level key lines
// for the downstream input manager. Receive-only; never drives the bus.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins
//   raw_*               held level, 1 while the mapped key is down
//   byte_valid          one-cycle pulse per good frame
//   byte_data           last good byte, held between pulses
//   frame_err           one-cycle pulse per bad frame (start/parity/stop)
module ps2_keyboard_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate_cw,
  output logic       raw_rotate_ccw,
  output logic       raw_drop,
  output logic       raw_hold,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);

  // Key vector bit order: 0 left, 1 right, 2 down, 3 cw, 4 ccw, 5 drop, 6 hold
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [9:0]    shift_q, shift_d;
  logic [10:0]   frame;
  logic          bv_q, bv_d, fe_q, fe_d;
  logic [7:0]    bdata_q, bdata_d;
  state_t        state_q, state_d;
  logic [6:0]    keys_q, keys_d;

  function automatic logic [6:0] norm_mask(input logic [7:0] c);
    case (c)
      8'h1A:   norm_mask = 7'b001_0000;
      8'h29:   norm_mask = 7'b010_0000;
      8'h21:   norm_mask = 7'b100_0000;
      default: norm_mask = '0;
    endcase
  endfunction

  function automatic logic [6:0] ext_mask(input logic [7:0] c);
    case (c)
      8'h6B:   ext_mask = 7'b000_0001;
      8'h74:   ext_mask = 7'b000_0010;
      8'h72:   ext_mask = 7'b000_0100;
      8'h75:   ext_mask = 7'b000_1000;
      default: ext_mask = '0;
    endcase
  endfunction

  // Sync flops reset to 1 (idle bus level) so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // Bits shift in from the top; on the 11th edge the incoming bit is the stop
  // bit, so the complete frame is the current data bit over the 10 stored ones.
  assign frame = {dat_s2_q, shift_q};

  always_comb begin
    bitcnt_d = bitcnt_q;
    idle_d   = idle_q;
    shift_d  = shift_q;
    bv_d     = 1'b0;
    fe_d     = 1'b0;
    bdata_d  = bdata_q;
    if (fall) begin
      idle_d  = '0;
      shift_d = {dat_s2_q, shift_q[9:1]};
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = '0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          bv_d    = 1'b1;
          bdata_d = frame[8:1];
        end else begin
          fe_d = 1'b1;
        end
      end else begin
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0) begin
      if (idle_q == IDLE_MAX) begin
        bitcnt_d = '0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q <= '0;
      idle_q   <= '0;
      shift_q  <= '0;
      bv_q     <= 1'b0;
      fe_q     <= 1'b0;
      bdata_q  <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      idle_q   <= idle_d;
      shift_q  <= shift_d;
      bv_q     <= bv_d;
      fe_q     <= fe_d;
      bdata_q  <= bdata_d;
    end
  end

  // Decoder acts on the registered pulse, so key levels move on the edge
  // that ends the byte_valid cycle.
  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    if (fe_q) begin
      state_d = S_IDLE;
    end else if (bv_q) begin
      case (state_q)
        S_IDLE: begin
          if (bdata_q == 8'hE0)      state_d = S_EXT;
          else if (bdata_q == 8'hF0) state_d = S_BRK;
          else                       keys_d  = keys_q | norm_mask(bdata_q);
        end
        S_EXT: begin
          if (bdata_q == 8'hF0)      state_d = S_EXT_BRK;
          else if (bdata_q == 8'hE0) state_d = S_EXT;
          else begin
            keys_d  = keys_q | ext_mask(bdata_q);
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          keys_d  = keys_q & ~norm_mask(bdata_q);
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          keys_d  = keys_q & ~ext_mask(bdata_q);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
    end
  end

  assign raw_left       = keys_q[0];
  assign raw_right      = keys_q[1];
  assign raw_down       = keys_q[2];
  assign raw_rotate_cw  = keys_q[3];
  assign raw_rotate_ccw = keys_q[4];
  assign raw_drop       = keys_q[5];
  assign raw_hold       = keys_q[6];
  assign byte_valid     = bv_q;
  assign byte_data      = bdata_q;
  assign frame_err      = fe_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: drives PS/2 frames bit by bit
// and compares key levels, byte outputs and pulse counts with
// hand-computed values.
module tb_ps2_keyboard_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       raw_left, raw_right, raw_down, raw_rotate_cw;
  logic       raw_rotate_ccw, raw_drop, raw_hold;
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;
  logic [6:0] raw;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned bv_cnt = 0;
  int unsigned fe_cnt = 0;
  logic [6:0] raw_at_pulse = '0;
  logic [6:0] raw_after = '0;
  logic       bv_prev = 1'b0;

  ps2_keyboard_decoder #(.TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
    .raw_rotate_cw(raw_rotate_cw), .raw_rotate_ccw(raw_rotate_ccw),
    .raw_drop(raw_drop), .raw_hold(raw_hold),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign raw = {raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw,
                raw_down, raw_right, raw_left};

  // Counts pulse-high cycles and snapshots key levels around each byte_valid.
  always @(negedge clk) begin
    if (bv_prev) raw_after = raw;
    if (byte_valid) begin
      bv_cnt++;
      raw_at_pulse = raw;
    end
    if (frame_err) fe_cnt++;
    bv_prev = byte_valid;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit badpar);
    mk = {1'b1, (~^b) ^ badpar, b, 1'b0};
  endfunction

  // Half-period 20 clk: data set mid high phase, 20 low, 20 high per bit.
  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mk(b, 1'b0), 0, 10);
    repeat (20) @(negedge clk);
  endtask

  task automatic send_raw(input logic [10:0] f);
    send_bits(f, 0, 10);
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] f;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_raw", 32'(raw), 32'h00);
    check("rst_data", 32'(byte_data), 32'h00);
    check("rst_bv", 32'(byte_valid), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);

    // Space make/break
    send(8'h29);
    check("space_bv_cnt", bv_cnt, 1);
    check("space_data", 32'(byte_data), 32'h29);
    check("space_raw_at_pulse", 32'(raw_at_pulse), 32'h00);
    check("space_raw_after", 32'(raw_after), 32'h20);
    send(8'hF0); send(8'h29);
    check("space_break", 32'(raw), 32'h00);
    check("space_bv_cnt3", bv_cnt, 3);

    // Extended left, then plain 6B is ignored
    send(8'hE0); send(8'h6B);
    check("left_make", 32'(raw), 32'h01);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("left_break", 32'(raw), 32'h00);
    send(8'h6B);
    check("plain_6b_raw", 32'(raw), 32'h00);
    check("plain_6b_data", 32'(byte_data), 32'h6B);
    send(8'h72);
    check("kp2_ignored", 32'(raw), 32'h00);

    // Concurrent keys
    send(8'hE0); send(8'h72); send(8'h1A);
    check("down_ccw", 32'(raw), 32'h14);
    send(8'hF0); send(8'h1A);
    check("ccw_break", 32'(raw), 32'h04);

    // Parity error
    bv_cnt = 0; fe_cnt = 0;
    send_raw(mk(8'h21, 1'b1));
    check("par_fe_cnt", fe_cnt, 1);
    check("par_bv_cnt", bv_cnt, 0);
    check("par_raw", 32'(raw), 32'h04);
    check("par_data_held", 32'(byte_data), 32'h1A);
    send(8'h21);
    check("hold_make", 32'(raw), 32'h44);
    check("hold_bv_cnt", bv_cnt, 1);

    // Error recovery: F0, bad frame, 29 -> make
    send(8'hF0);
    send_raw(mk(8'h29, 1'b1));
    send(8'h29);
    check("recover_drop", 32'(raw), 32'h64);
    check("recover_fe_cnt", fe_cnt, 2);

    // Bad stop and bad start bits
    f = mk(8'h21, 1'b0); f[10] = 1'b0;
    send_raw(f);
    check("stop_fe_cnt", fe_cnt, 3);
    f = mk(8'h21, 1'b0); f[0] = 1'b1;
    send_raw(f);
    check("start_fe_cnt", fe_cnt, 4);
    check("bad_frames_raw", 32'(raw), 32'h64);

    // Timeout: 5 stray bits, long stall, then E0 75
    send_bits(mk(8'hF0, 1'b0), 0, 4);
    repeat (200) @(negedge clk);
    send(8'hE0); send(8'h75);
    check("timeout_cw", 32'(raw), 32'h6C);
    check("timeout_no_fe", fe_cnt, 4);

    // Stall shorter than the timeout: frame continues
    bv_cnt = 0;
    send_bits(mk(8'h1A, 1'b0), 0, 4);
    repeat (120) @(negedge clk);
    send_bits(mk(8'h1A, 1'b0), 5, 10);
    repeat (20) @(negedge clk);
    check("stall_bv_cnt", bv_cnt, 1);
    check("stall_data", 32'(byte_data), 32'h1A);
    check("stall_raw", 32'(raw), 32'h7C);

    // Reset clears levels and byte_data
    pulse_rst();
    check("rst2_raw", 32'(raw), 32'h00);
    check("rst2_data", 32'(byte_data), 32'h00);

    // Reset mid-frame discards the partial bits
    send_bits(mk(8'h21, 1'b0), 0, 5);
    pulse_rst();
    send(8'h29);
    check("midrst_raw", 32'(raw), 32'h20);
    check("midrst_data", 32'(byte_data), 32'h29);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
